// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/owner types and block geometry for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DRAIN} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int WORD_BYTES          = 2;
  localparam int WORD_OFF_W          = $clog2(WORD_BYTES);
  localparam int DEF_WORDS_PER_BLOCK = 8;

  function automatic int blk_off_w(input int words);
    return $clog2(words * WORD_BYTES);
  endfunction

  localparam int BLK_OFF_W = blk_off_w(DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - issue/return word counters for one block-fill burst
module fill_counter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WIDX_W          = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              issue_inc,
  input  logic              ret_inc,
  output logic [WIDX_W-1:0] issue_idx,
  output logic [WIDX_W-1:0] ret_idx,
  output logic              issue_last,
  output logic              done
);

  localparam logic [WIDX_W:0] LAST = (WIDX_W+1)'(WORDS_PER_BLOCK - 1);
  localparam logic [WIDX_W:0] ONE  = (WIDX_W+1)'(1);

  // One spare bit so the issue counter may step past the last word without wrapping.
  logic [WIDX_W:0] issue_cnt;
  logic [WIDX_W:0] ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_inc) issue_cnt <= issue_cnt + ONE;
      if (ret_inc)   ret_cnt   <= ret_cnt + ONE;
    end
  end

  assign issue_idx  = issue_cnt[WIDX_W-1:0];
  assign ret_idx    = ret_cnt[WIDX_W-1:0];
  assign issue_last = (issue_cnt == LAST);
  assign done       = ret_inc && (ret_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared main-memory arbiter for I/D fills and D stores
// Optional I-side starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WIDX_W          = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_miss_req,
  input  logic [15:0]       I_miss_addr,
  input  logic              D_miss_req,
  input  logic [15:0]       D_miss_addr,
  input  logic              D_wr_req,
  input  logic [15:0]       D_wr_addr,
  input  logic [15:0]       D_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       fill_data,
  output logic [WIDX_W-1:0] fill_widx,
  output logic              I_fill_we,
  output logic              D_fill_we,
  output logic              I_fill_done,
  output logic              D_fill_done,
  output logic              D_wr_ack,
  output logic              busy
);

  localparam int OFF_W  = blk_off_w(WORDS_PER_BLOCK);
  localparam int BASE_W = 16 - OFF_W;

  arb_state_t        state, state_nx;
  owner_t            owner;
  logic [BASE_W-1:0] base;
  logic [15:0]       wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              grant_wr, grant_dm, grant_im;
  logic              starve_force;
  logic              ret_fire;
  logic              issue_last;
  logic              fill_done;
  logic [WIDX_W-1:0] issue_idx;
  logic [WIDX_W-1:0] ret_idx;

  // Word-offset bits of miss addresses are meaningless: fills always start at word 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_miss_addr[OFF_W-1:0], D_miss_addr[OFF_W-1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= 2'd0;
    else if (grant_im || !I_miss_req)
      starve_cnt <= 2'd0;
    else if ((grant_wr || grant_dm) && starve_cnt != 2'd3)
      starve_cnt <= starve_cnt + 2'd1;
  end

  assign starve_force = I_miss_req && (starve_cnt == 2'd3);
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    grant_wr = 1'b0;
    grant_dm = 1'b0;
    grant_im = 1'b0;
    if (state == IDLE) begin
      if (starve_force)    grant_im = 1'b1;
      else if (D_wr_req)   grant_wr = 1'b1;
      else if (D_miss_req) grant_dm = 1'b1;
      else if (I_miss_req) grant_im = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_I;
      base      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state <= state_nx;
      if (grant_wr) begin
        wr_addr_q <= D_wr_addr;
        wr_data_q <= D_wr_data;
      end
      if (grant_dm) begin
        owner <= OWN_D;
        base  <= D_miss_addr[15:OFF_W];
      end else if (grant_im) begin
        owner <= OWN_I;
        base  <= I_miss_addr[15:OFF_W];
      end
    end
  end

  // Returns are counted in order of arrival only, so memory latency is irrelevant.
  assign ret_fire = ((state == FILL) || (state == DRAIN)) && mem_rvalid;

  fill_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .WIDX_W          (WIDX_W)
  ) u_fill_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (grant_dm || grant_im),
    .issue_inc  (state == FILL),
    .ret_inc    (ret_fire),
    .issue_idx  (issue_idx),
    .ret_idx    (ret_idx),
    .issue_last (issue_last),
    .done       (fill_done)
  );

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    D_wr_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_wr)                   state_nx = WRITE;
        else if (grant_dm || grant_im)  state_nx = FILL;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
        D_wr_ack  = 1'b1;
        state_nx  = IDLE;
      end
      FILL: begin
        mem_en   = 1'b1;
        mem_addr = {base, issue_idx, {WORD_OFF_W{1'b0}}};
        if (fill_done)       state_nx = IDLE;
        else if (issue_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (fill_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fill_data   = ret_fire ? mem_rdata : '0;
  assign fill_widx   = ret_fire ? ret_idx : '0;
  assign I_fill_we   = ret_fire && (owner == OWN_I);
  assign D_fill_we   = ret_fire && (owner == OWN_D);
  assign I_fill_done = fill_done && (owner == OWN_I);
  assign D_fill_done = fill_done && (owner == OWN_D);
  assign busy        = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared unified main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the two caches and the multi-cycle main memory in the pipelined CPU.
- Issues block-fill address bursts and counts returned words.
- Steers fill data to the owning cache and signals completion with a pulse.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2.
- WIDX_W, 3, width of the word index; equals log2(WORDS_PER_BLOCK).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- I_miss_req  in  1  I-cache miss; level, held until I_fill_done
- I_miss_addr  in  16  I-cache miss byte address
- D_miss_req  in  1  D-cache miss; level, held until D_fill_done
- D_miss_addr  in  16  D-cache miss byte address
- D_wr_req  in  1  D-cache store request; level, held until D_wr_ack
- D_wr_addr  in  16  store byte address
- D_wr_data  in  16  store data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- fill_data  out  16  fill word to the caches (mem_rdata pass-through)
- fill_widx  out  WIDX_W  word index of fill_data within the block
- I_fill_we  out  1  I-cache fill write strobe
- D_fill_we  out  1  D-cache fill write strobe
- I_fill_done  out  1  one-cycle pulse, I fill complete
- D_fill_done  out  1  one-cycle pulse, D fill complete
- D_wr_ack  out  1  one-cycle pulse, store issued
- busy  out  1  arbiter not in IDLE

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous, active-low. On assertion, state goes to IDLE immediately, even mid-burst. All counters and captured registers clear. Every output is 0.
- States: IDLE, WRITE, FILL, DRAIN.
- IDLE: samples requests at the clock edge with fixed priority D_wr_req > D_miss_req > I_miss_req.
  - Store winner: capture addr/data, go to WRITE.
  - Miss winner: capture owner (I/D) and block base = addr[15:4] (for default WORDS_PER_BLOCK), clear counters, go to FILL.
- WRITE: one cycle. Drives mem_en=1, mem_wr=1, mem_addr/mem_wdata from the captured registers, and D_wr_ack=1. Returns to IDLE.
- FILL: mem_en=1, mem_wr=0, mem_addr={base, issue_cnt, 1'b0}. issue_cnt runs 0..WORDS_PER_BLOCK-1, one address per cycle. After the last issue, go to DRAIN.
- DRAIN: mem_en=0. Waits for the remaining returns.
- Returns, in FILL or DRAIN when mem_rvalid=1:
  - fill_data=mem_rdata, fill_widx=ret_cnt.
  - The owner's fill_we=1; ret_cnt increments.
  - On the return with ret_cnt==WORDS_PER_BLOCK-1, the owner's done pulse is asserted in the same cycle as the final fill_we. Next state is IDLE.
- Returns always arrive in issue order. Fill writes are counted by rvalid only, so the block is latency-agnostic.
- mem_rvalid while in IDLE or WRITE is ignored: no fill_we, no counter change.
- Requests arriving during busy are held by the requester and arbitrated at the next IDLE. The minimum gap between grants is one IDLE cycle.
- Requester drops its req on the edge where it sees done or ack; IDLE samples afterwards, so no double grant occurs.
- Counters are WIDX_W+1 bits and do not wrap within one burst.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: a 2-bit saturating counter counts consecutive D-side grants (store or miss) while I_miss_req is pending.
  - At 3, the next IDLE grant goes to I_miss_req regardless of D requests.
  - Counter clears on any I grant or when I_miss_req is low.
- Undefined: strict fixed priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg contains:
  - state enum arb_state_t {IDLE, WRITE, FILL, DRAIN}
  - owner enum owner_t {OWN_I, OWN_D}
  - localparams WORD_BYTES=2 and BLK_OFF_W=log2(WORDS_PER_BLOCK*WORD_BYTES)
- Sub-module fill_counter: issue and return counters with clear, increment, last-flags and done generation.

Test Plan:
1. Reset mid-burst: assert rst_n=0 during FILL at issue_cnt=3. All outputs go to 0 asynchronously. After release, state is IDLE and the next D_miss_req starts at word 0.
2. D miss at 0x1234 with a 4-cycle-latency memory model:
   - mem_addr = 0x1230, 0x1232, … 0x123E on 8 consecutive cycles.
   - 8 D_fill_we with fill_widx 0..7.
   - D_fill_done coincides with the 8th write.
   - I_fill_we is never asserted.
3. Simultaneous D_wr_req (0x0040, data 0xBEEF), D_miss_req and I_miss_req:
   - WRITE is issued first with mem_wr=1, addr 0x0040, data 0xBEEF and a D_wr_ack pulse.
   - Then the D fill, then the I fill.
4. I miss at 0xFFFE with memory that inserts rvalid gaps (valid on alternate cycles): addresses 0xFFF0..0xFFFE, DRAIN holds until the 8th rvalid, I_fill_done issues once, and busy drops the next cycle.
5. Spurious mem_rvalid in IDLE with data 0x1111: no fill_we, no done; the next fill starts with fill_widx=0.
6. With MEM_ARB_STARVE_GUARD_EN: hold I_miss_req high while D requests are continuous. The I fill is granted after exactly 3 D grants. Without the macro, the I fill waits until D requests stop.
